// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_pipe_reg
// Brief   : ID->EX pipeline register with valid/ready handshake, flush and an
//           optional one-entry skid buffer (enable with `define ID_EX_SKID_EN).
// Revision: 1.0  initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cu_flush_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [XLEN-1:0]   id_op_a_i,
    input  logic [XLEN-1:0]   id_op_b_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [CTRL_W-1:0] id_alu_ctrl_i,
    input  logic [RA_W-1:0]   id_rd_i,
    input  logic              id_wb_en_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   ex_op_a_o,
    output logic [XLEN-1:0]   ex_op_b_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [CTRL_W-1:0] ex_alu_ctrl_o,
    output logic [RA_W-1:0]   ex_rd_o,
    output logic              ex_wb_en_o
);

    typedef struct packed {
        logic [XLEN-1:0]   op_a;
        logic [XLEN-1:0]   op_b;
        logic [XLEN-1:0]   pc;
        logic [CTRL_W-1:0] alu_ctrl;
        logic [RA_W-1:0]   rd;
        logic              wb_en;
    } payload_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t   m_state;
    state_t   m_state_nxt;
    payload_t m_data;
    payload_t m_next_data;
    payload_t in_data;
    logic     m_load;
    logic     m_load_in;
    logic     in_xfer;
    logic     out_xfer;

    assign in_data  = {id_op_a_i, id_op_b_i, id_pc_i, id_alu_ctrl_i, id_rd_i, id_wb_en_i};
    assign in_xfer  = id_valid_i && id_ready_o;
    assign out_xfer = (m_state == FULL) && ex_ready_i;

`ifdef ID_EX_SKID_EN
    logic     s_valid;
    logic     s_valid_nxt;
    payload_t s_data;
    logic     m_load_s;
    logic     s_load;

    // Ready comes straight from a flop, breaking the ex_ready_i -> id_ready_o path.
    assign id_ready_o  = !s_valid;
    assign m_load      = m_load_in || m_load_s;
    assign m_next_data = m_load_s ? s_data : in_data;

    always_comb begin
        m_state_nxt = m_state;
        s_valid_nxt = s_valid;
        m_load_in   = 1'b0;
        m_load_s    = 1'b0;
        s_load      = 1'b0;
        if (cu_flush_i) begin
            m_state_nxt = EMPTY;
            s_valid_nxt = 1'b0;
        end else if (m_state == EMPTY) begin
            if (in_xfer) begin
                m_load_in   = 1'b1;
                m_state_nxt = FULL;
            end
        end else if (out_xfer) begin
            if (s_valid) begin
                // Skid entry is older than the input; it moves up first.
                m_load_s    = 1'b1;
                s_load      = in_xfer;
                s_valid_nxt = in_xfer;
            end else if (in_xfer) begin
                m_load_in = 1'b1;
            end else begin
                m_state_nxt = EMPTY;
            end
        end else if (in_xfer) begin
            s_load      = 1'b1;
            s_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else begin
            s_valid <= s_valid_nxt;
            if (s_load) begin
                s_data <= in_data;
            end
        end
    end
`else
    assign id_ready_o  = (m_state == EMPTY) || ex_ready_i;
    assign m_load      = m_load_in;
    assign m_next_data = in_data;

    always_comb begin
        m_state_nxt = m_state;
        m_load_in   = 1'b0;
        if (cu_flush_i) begin
            m_state_nxt = EMPTY;
        end else if (in_xfer) begin
            m_load_in   = 1'b1;
            m_state_nxt = FULL;
        end else if (out_xfer) begin
            m_state_nxt = EMPTY;
        end
    end
`endif

    // Payload is only cleared by reset; flush and drain leave it in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_state <= EMPTY;
            m_data  <= '0;
        end else begin
            m_state <= m_state_nxt;
            if (m_load) begin
                m_data <= m_next_data;
            end
        end
    end

    assign ex_valid_o    = (m_state == FULL);
    assign ex_op_a_o     = m_data.op_a;
    assign ex_op_b_o     = m_data.op_b;
    assign ex_pc_o       = m_data.pc;
    assign ex_alu_ctrl_o = m_data.alu_ctrl;
    assign ex_rd_o       = m_data.rd;
    assign ex_wb_en_o    = m_data.wb_en & ex_valid_o;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_pipe_reg
// Brief   : Scoreboard bench for id_ex_pipe_reg (32-bit and 64-bit instances).
// Revision: 1.0  initial release
// ============================================================================
module tb_id_ex_pipe_reg;

`ifdef ID_EX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, cu_flush_i, id_valid_i, id_ready_o, id_wb_en_i;
    logic [31:0] id_op_a_i, id_op_b_i, id_pc_i;
    logic [3:0]  id_alu_ctrl_i;
    logic [4:0]  id_rd_i;
    logic        ex_valid_o, ex_ready_i, ex_wb_en_o;
    logic [31:0] ex_op_a_o, ex_op_b_o, ex_pc_o;
    logic [3:0]  ex_alu_ctrl_o;
    logic [4:0]  ex_rd_o;

    logic        id_valid64, id_ready64, id_wb_en64, ex_valid64, ex_ready64, ex_wb_en64;
    logic [63:0] id_op_a64, id_op_b64, id_pc64, ex_op_a64, ex_op_b64, ex_pc64;
    logic [5:0]  id_alu_ctrl64, ex_alu_ctrl64;
    logic [4:0]  id_rd64, ex_rd64;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_out    = 0;
    logic [31:0] sb[$];
    logic        acc, rdy_seen, vl_seen;
    logic [31:0] oa_seen;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .cu_flush_i(cu_flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_op_a_i(id_op_a_i), .id_op_b_i(id_op_b_i), .id_pc_i(id_pc_i),
        .id_alu_ctrl_i(id_alu_ctrl_i), .id_rd_i(id_rd_i), .id_wb_en_i(id_wb_en_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_op_a_o(ex_op_a_o), .ex_op_b_o(ex_op_b_o), .ex_pc_o(ex_pc_o),
        .ex_alu_ctrl_o(ex_alu_ctrl_o), .ex_rd_o(ex_rd_o), .ex_wb_en_o(ex_wb_en_o)
    );

    id_ex_pipe_reg #(.XLEN(64), .CTRL_W(6), .RA_W(5)) dut64 (
        .clk(clk), .rst(rst), .cu_flush_i(1'b0),
        .id_valid_i(id_valid64), .id_ready_o(id_ready64),
        .id_op_a_i(id_op_a64), .id_op_b_i(id_op_b64), .id_pc_i(id_pc64),
        .id_alu_ctrl_i(id_alu_ctrl64), .id_rd_i(id_rd64), .id_wb_en_i(id_wb_en64),
        .ex_valid_o(ex_valid64), .ex_ready_i(ex_ready64),
        .ex_op_a_o(ex_op_a64), .ex_op_b_o(ex_op_b64), .ex_pc_o(ex_pc64),
        .ex_alu_ctrl_o(ex_alu_ctrl64), .ex_rd_o(ex_rd64), .ex_wb_en_o(ex_wb_en64)
    );

    function automatic void chk(string nm, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h required %0h", nm, got, exp);
    endfunction

    // Payload fields are derived from op_a so one tag identifies the whole word.
    function automatic logic [31:0] f_opb(logic [31:0] a);
        return a ^ 32'hFFFF_0000;
    endfunction
    function automatic logic [3:0] f_ctrl(logic [31:0] a);
        logic [3:0] lo;
        lo = a[3:0];
        return lo ^ 4'h5;
    endfunction
    function automatic logic [127:0] f_pay(logic [31:0] a);
        logic [4:0] rd;
        rd = a[4:0];
        return {22'b0, a, f_opb(a), a << 2, f_ctrl(a), rd, 1'b1};
    endfunction

    // One clock: drive at posedge+1, record the handshake, return at next posedge+1.
    task automatic cyc(input logic v, input logic [31:0] a, input logic rdy,
                       input logic fl, input logic rs);
        id_valid_i    = v;
        id_op_a_i     = a;
        id_op_b_i     = f_opb(a);
        id_pc_i       = a << 2;
        id_alu_ctrl_i = f_ctrl(a);
        id_rd_i       = a[4:0];
        id_wb_en_i    = 1'b1;
        ex_ready_i    = rdy;
        cu_flush_i    = fl;
        rst           = rs;
        @(negedge clk);
        #1;
        rdy_seen = id_ready_o;
        vl_seen  = ex_valid_o;
        oa_seen  = ex_op_a_o;
        acc      = v && id_ready_o && !fl && !rs;
        if (rs || fl) sb.delete();
        else if (acc) sb.push_back(a);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (!ex_valid_o) chk("wb_gate", ex_wb_en_o, 0);
            if (ex_valid_o && ex_ready_i) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output got op_a=%0h required no output", ex_op_a_o);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    chk("sb_payload",
                        {22'b0, ex_op_a_o, ex_op_b_o, ex_pc_o, ex_alu_ctrl_o, ex_rd_o, ex_wb_en_o},
                        f_pay(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    logic        rdy_log[10];
    logic        vl_log[10];
    logic [31:0] oa_log[10];
    int          idx, out0;

    initial begin
        rst = 1'b1; cu_flush_i = 1'b0; id_valid_i = 1'b0; ex_ready_i = 1'b1;
        id_op_a_i = '0; id_op_b_i = '0; id_pc_i = '0; id_alu_ctrl_i = '0;
        id_rd_i = '0; id_wb_en_i = 1'b0;
        id_valid64 = 1'b0; ex_ready64 = 1'b1; id_op_a64 = '0; id_op_b64 = '0;
        id_pc64 = '0; id_alu_ctrl64 = '0; id_rd64 = '0; id_wb_en64 = 1'b0;
        @(posedge clk);
        #1;

        // Reset then stream
        cyc(0, 32'h0, 1, 0, 1);
        cyc(0, 32'h0, 1, 0, 1);
        chk("rst_valid", ex_valid_o, 0);
        chk("rst_payload", {ex_op_a_o, ex_op_b_o, ex_pc_o, ex_alu_ctrl_o, ex_rd_o, ex_wb_en_o}, 0);
        chk("rst_ready", id_ready_o, 1);
        cyc(1, 32'h11, 1, 0, 0);
        chk("stream_v0", ex_valid_o, 1); chk("stream_a0", ex_op_a_o, 32'h11);
        cyc(1, 32'h22, 1, 0, 0);
        chk("stream_v1", ex_valid_o, 1); chk("stream_a1", ex_op_a_o, 32'h22);
        cyc(1, 32'h33, 1, 0, 0);
        chk("stream_v2", ex_valid_o, 1); chk("stream_a2", ex_op_a_o, 32'h33);
        cyc(0, 32'h0, 1, 0, 0);
        chk("stream_drain", ex_valid_o, 0);

        // Backpressure: ex_ready_i low during loop cycles 2..4
        idx  = 0;
        out0 = n_out;
        for (int c = 0; c < 10; c++) begin
            cyc(idx < 4, 32'hA0 + 32'(idx), !(c >= 2 && c <= 4), 0, 0);
            rdy_log[c] = rdy_seen;
            vl_log[c]  = vl_seen;
            oa_log[c]  = oa_seen;
            if (acc) idx++;
        end
        chk("bp_ready_c1", rdy_log[1], 1);
        chk("bp_ready_c2", rdy_log[2], SKID ? 1 : 0);
        chk("bp_ready_c3", rdy_log[3], 0);
        chk("bp_ready_c5", rdy_log[5], SKID ? 0 : 1);
        for (int c = 2; c <= 4; c++) begin
            chk("bp_hold_valid", vl_log[c], 1);
            chk("bp_hold_op_a", oa_log[c], 32'hA1);
        end
        chk("bp_accepted", idx, 4);
        chk("bp_delivered", n_out - out0, 4);
        chk("bp_sb_empty", sb.size(), 0);

        // Flush with the stage holding as much as it can
        cyc(1, 32'hB0, 0, 0, 0);
        cyc(1, 32'hB1, 0, 0, 0);
        chk("fl_pre_valid", ex_valid_o, 1);
        chk("fl_pre_op_a", ex_op_a_o, 32'hB0);
        chk("fl_pre_ready", id_ready_o, 0);
        cyc(1, 32'h77, 0, 1, 0);
        chk("fl_cycle_ready", rdy_seen, 0);
        chk("fl_valid", ex_valid_o, 0);
        chk("fl_wb", ex_wb_en_o, 0);
        chk("fl_payload_hold", ex_op_a_o, 32'hB0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        chk("fl_after_valid", ex_valid_o, 0);
        chk("fl_after_ready", id_ready_o, 1);

        // Bubble between write-back payloads
        cyc(1, 32'hC0, 1, 0, 0);
        chk("bub_v0", ex_valid_o, 1); chk("bub_wb0", ex_wb_en_o, 1); chk("bub_a0", ex_op_a_o, 32'hC0);
        cyc(0, 32'hC1, 1, 0, 0);
        chk("bub_v1", ex_valid_o, 0); chk("bub_wb1", ex_wb_en_o, 0); chk("bub_hold", ex_op_a_o, 32'hC0);
        cyc(1, 32'hC2, 1, 0, 0);
        chk("bub_v2", ex_valid_o, 1); chk("bub_wb2", ex_wb_en_o, 1); chk("bub_a2", ex_op_a_o, 32'hC2);
        cyc(0, 32'h0, 1, 0, 0);

        // Reset beats flush while stalled
        cyc(1, 32'h40, 0, 0, 0);
        chk("rf_pc", ex_pc_o, 32'h100);
        cyc(0, 32'h0, 0, 0, 0);
        chk("rf_stall_valid", ex_valid_o, 1);
        chk("rf_stall_pc", ex_pc_o, 32'h100);
        cyc(0, 32'h0, 0, 1, 1);
        chk("rf_valid", ex_valid_o, 0);
        chk("rf_payload", {ex_op_a_o, ex_op_b_o, ex_pc_o, ex_alu_ctrl_o, ex_rd_o, ex_wb_en_o}, 0);
        chk("rf_ready", id_ready_o, 1);
        cyc(0, 32'h0, 1, 0, 0);

        // 64-bit instance pass-through
        chk("w64_ready", id_ready64, 1);
        id_valid64    = 1'b1;
        id_op_a64     = 64'h8000_0000_0000_0001;
        id_op_b64     = 64'hFFFF_FFFF_0000_0001;
        id_pc64       = 64'h0000_0001_0000_0004;
        id_alu_ctrl64 = 6'h2A;
        id_rd64       = 5'h1F;
        id_wb_en64    = 1'b1;
        @(posedge clk);
        #1;
        id_valid64 = 1'b0;
        chk("w64_valid", ex_valid64, 1);
        chk("w64_op_a", ex_op_a64, 64'h8000_0000_0000_0001);
        chk("w64_op_b", ex_op_b64, 64'hFFFF_FFFF_0000_0001);
        chk("w64_pc", ex_pc64, 64'h0000_0001_0000_0004);
        chk("w64_ctrl", ex_alu_ctrl64, 6'h2A);
        chk("w64_rd_wb", {ex_rd64, ex_wb_en64}, {5'h1F, 1'b1});
        @(posedge clk);
        #1;
        chk("w64_drain", ex_valid64, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID→EX pipeline register with a valid/ready handshake, synchronous flush and an optional skid buffer. It sits between the decode stage and the execute stage. It carries both ALU operands, the ALU control word, the destination register address, the write-back enable and the PC. It replaces the free-running operand register with a stage that can stall, take bubbles and be killed by the control unit.

## Interface
- XLEN, 32: operand and PC width.
- CTRL_W, 4: ALU control word width.
- RA_W, 5: register address width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cu_flush_i  in  1  kill all held instructions; from control unit.
- id_valid_i  in  1  decode presents an instruction.
- id_ready_o  out  1  stage accepts this cycle.
- id_op_a_i, id_op_b_i  in  XLEN  ALU operands.
- id_pc_i  in  XLEN  instruction PC.
- id_alu_ctrl_i  in  CTRL_W  ALU operation.
- id_rd_i  in  RA_W  destination register.
- id_wb_en_i  in  1  register write-back enable.
- ex_valid_o  out  1  execute payload valid.
- ex_ready_i  in  1  execute consumes this cycle.
- ex_op_a_o, ex_op_b_o, ex_pc_o  out  XLEN  registered payload.
- ex_alu_ctrl_o  out  CTRL_W  registered payload.
- ex_rd_o  out  RA_W  registered payload.
- ex_wb_en_o  out  1  registered payload, gated: always 0 when ex_valid_o=0.

## Operation
- Input transfer: id_valid_i && id_ready_o. Output transfer: ex_valid_o && ex_ready_i.
- Main register (M) drives the ex_* outputs. Its state is EMPTY or FULL; ex_valid_o = FULL.
- M loads on an input transfer when it is EMPTY or when it is emptied by an output transfer in the same cycle.
- M goes EMPTY after an output transfer with no replacement.
- Payload registers hold their value while M is EMPTY or stalled. Only reset zeroes them.
- ex_wb_en_o = M.wb_en & ex_valid_o, so a bubble never writes back.
- Flush: when cu_flush_i=1, M and the skid entry go EMPTY at the next edge, and any input transfer in the same cycle is discarded. The id_ready_o value in the flush cycle is unchanged; the flush takes priority over all loads.
- Reset (rst=1 at an edge) takes priority over flush. All ex_* outputs become 0, the stage goes EMPTY and id_ready_o=1. A reset mid-stall drops the held instruction.
- Arithmetic: none. All fields pass through bit-exact at the parameter widths.

## Timing
- Latency: 1 cycle from input transfer to ex_valid_o=1.
- Throughput: 1 instruction/cycle while ex_ready_i=1.
- ex_valid_o and the payload are stable while ex_valid_o=1 && ex_ready_i=0 (no-drop, no-change rule).
- id_ready_o depends on the configuration; see Configuration.
- Simultaneous input and output transfer while FULL: M takes the new instruction, with no bubble.

## Configuration
- Macro: ID_EX_SKID_EN.
- Defined:
  - Adds a one-entry skid register S. id_ready_o = !S.valid, driven purely from a register with no combinational path from ex_ready_i.
  - Input transfer while M is FULL and ex_ready_i=0 writes S.
  - When M is emptied by an output transfer and S is valid, M loads from S and S clears. In that cycle the input stream, if it is transferring, refills S.
  - Ordering is preserved: S is always older than the input.
- Undefined:
  - No S. id_ready_o = !ex_valid_o || ex_ready_i (combinational).
  - All other behaviour is identical.

## Test plan
- Reset then stream: assert rst 2 cycles → all ex_* = 0, id_ready_o=1. Then send op_a=0x11,0x22,0x33 back-to-back with ex_ready_i=1 → ex_op_a_o shows 0x11,0x22,0x33 on consecutive cycles, each one cycle after its input.
- Backpressure, skid build: drop ex_ready_i for 3 cycles during a stream of 0xA0..0xA3.
  - With ID_EX_SKID_EN: id_ready_o falls one cycle after the first stall cycle.
  - Without: id_ready_o falls the same cycle.
  - Either way, output order is 0xA0,0xA1,0xA2,0xA3 with none lost or duplicated, and the payload is held while stalled.
- Flush with both entries full (macro defined): assert cu_flush_i with id_valid_i=1, op_a=0x77 → next cycle ex_valid_o=0 and ex_wb_en_o=0. 0x77 never appears at the output.
- Bubble: id_valid_i=0 for 1 cycle with wb_en=1 payloads around it → ex_valid_o=0 and ex_wb_en_o=0 for exactly one cycle, and the payload holds its last value.
- Reset beats flush: rst=1 and cu_flush_i=1 in the same cycle while stalled with pc=0x100 → all outputs 0 next cycle and id_ready_o=1.
- Parameter sweep: XLEN=64, CTRL_W=6, op_b=0xFFFF_FFFF_0000_0001 → passes bit-exact.
